// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says datapath: the symbol type,
// the sequence memory depth, the player FSM states and the 7-segment encoder.
package simon_pkg;

  typedef logic [1:0] symbol_t;

  localparam int SEQ_DEPTH = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ON,
    OFF,
    DONE
  } player_state_t;

  // Active-low segments {g,f,e,d,c,b,a}; anything outside 0..9 is blank.
  function automatic logic [6:0] seg7_digit(input logic [3:0] i_digit);
    logic [6:0] w_seg;
    case (i_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'h7F;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder: input value v lights output bit v.
module decoder_2_4 (
  input  logic [1:0] i_sel,
  output logic [3:0] o_onehot
);

  // Pure decode, no state.
  always_comb begin
    o_onehot = 4'b0000;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/sequence_player.sv
// sequence_player: replays the first `length` symbols of the Simon sequence
// memory on the LEDs, each lit for an ON window followed by a dark OFF gap.
//
// state | meaning
// IDLE  | waiting for start; LEDs dark, rd_addr 0
// FETCH | one cycle: capture the symbol at rd_addr = idx
// ON    | symbol shown one-hot for ON_UNITS*TICKS_PER_UNIT cycles
// OFF   | dark gap for OFF_UNITS*TICKS_PER_UNIT cycles, then next or finish
// DONE  | one cycle: done pulse, return to IDLE
//
// Optional build macro SEQ_PLAYER_HEX_EN adds hex_out, showing the current
// index on an active-low 7-segment digit.
module sequence_player
  import simon_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 25_000_000,
  parameter int unsigned ON_UNITS       = 1,
  parameter int unsigned OFF_UNITS      = 1,
  parameter int unsigned DEPTH          = SEQ_DEPTH
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] length,
  output logic [3:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic [3:0] led_out,
  output logic       busy,
`ifdef SEQ_PLAYER_HEX_EN
  output logic [6:0] hex_out,
`endif
  output logic       done
);

  localparam int unsigned ON_CYC  = ON_UNITS * TICKS_PER_UNIT;
  localparam int unsigned OFF_CYC = OFF_UNITS * TICKS_PER_UNIT;
  localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int          CW      = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    DEPTH_L  = 4'(DEPTH);

  player_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [3:0]    r_len;
  symbol_t       r_symbol;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    w_len_clamped;
  logic [3:0]    w_onehot;

  assign w_len_clamped = (length > DEPTH_L) ? DEPTH_L : length;

  decoder_2_4 u_dec (
    .i_sel    (r_symbol),
    .o_onehot (w_onehot)
  );

  // Playback FSM: index, timing down-counter, latched length and symbol.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= 4'd0;
      r_len    <= 4'd0;
      r_symbol <= 2'b00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len  <= w_len_clamped;
            r_idx  <= 4'd0;
            r_busy <= 1'b1;
            if (w_len_clamped != 4'd0) begin
              r_state <= FETCH;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          r_symbol <= rd_data;
          r_cnt    <= ON_LOAD;
          r_state  <= ON;
        end
        ON: begin
          if (r_cnt == '0) begin
            r_cnt   <= OFF_LOAD;
            r_state <= OFF;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        OFF: begin
          if (r_cnt == '0) begin
            if (r_idx == r_len - 4'd1) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= FETCH;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= 4'd0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= 4'd0;
        end
      endcase
    end
  end

  // LEDs are driven only while in ON; the symbol register is stable there.
  always_comb begin
    led_out = 4'b0000;
    if (r_state == ON) led_out = w_onehot;
  end

  assign rd_addr = r_idx;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef SEQ_PLAYER_HEX_EN
  logic [6:0] r_hex;

  // Digit follows idx one cycle late; blank outside active playback.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= 7'h7F;
    end else if (r_state == FETCH || r_state == ON || r_state == OFF) begin
      r_hex <= seg7_digit(r_idx);
    end else begin
      r_hex <= 7'h7F;
    end
  end

  assign hex_out = r_hex;
`endif

endmodule

// File: tb/tb_sequence_player.sv
// Directed testbench for sequence_player. Two instances share the clock:
// u_dut with unit timing (1/1/1) and u_dut2 with TICKS=2, ON=2, OFF=1.
module tb_sequence_player;

  logic       clk;
  logic       rst_n;
  logic       start1, start2;
  logic [3:0] length1, length2;
  logic [3:0] rd_addr1, rd_addr2;
  logic [1:0] rd_data1, rd_data2;
  logic [3:0] led1, led2;
  logic       busy1, busy2, done1, done2;
`ifdef SEQ_PLAYER_HEX_EN
  logic [6:0] hex1, hex2;
`endif

  logic [1:0] mem1 [0:15];
  logic [1:0] mem2 [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  assign rd_data1 = mem1[rd_addr1];
  assign rd_data2 = mem2[rd_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sequence_player #(.TICKS_PER_UNIT(1), .ON_UNITS(1), .OFF_UNITS(1), .DEPTH(10)) u_dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .length   (length1),
    .rd_addr  (rd_addr1),
    .rd_data  (rd_data1),
    .led_out  (led1),
    .busy     (busy1),
`ifdef SEQ_PLAYER_HEX_EN
    .hex_out  (hex1),
`endif
    .done     (done1)
  );

  sequence_player #(.TICKS_PER_UNIT(2), .ON_UNITS(2), .OFF_UNITS(1), .DEPTH(10)) u_dut2 (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .length   (length2),
    .rd_addr  (rd_addr2),
    .rd_data  (rd_data2),
    .led_out  (led2),
    .busy     (busy2),
`ifdef SEQ_PLAYER_HEX_EN
    .hex_out  (hex2),
`endif
    .done     (done2)
  );

  function automatic logic [3:0] oh(input logic [1:0] v);
    logic [3:0] r;
    r = 4'b0000;
    r[v] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b1; start2 = 1'b1; length1 = 4'd3; length2 = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (led1 !== 4'b0000 || busy1 !== 1'b0 || done1 !== 1'b0 || rd_addr1 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: led=%b busy=%b done=%b rd_addr=%0d, required 0000 0 0 0",
               led1, busy1, done1, rd_addr1);
    end
    start1 = 1'b0; start2 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if (busy1 !== 1'b0 || led1 !== 4'b0000 || done1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b led=%b done=%b busy2=%b, required 0 0000 0 0",
               busy1, led1, done1, busy2);
    end
  endtask

  task automatic test_single();
    mem1[0] = 2'b10; length1 = 4'd1;
    start1 = 1'b1;
    step(); start1 = 1'b0;                     // cycle 1: FETCH
    n_checks++;
    if (busy1 !== 1'b1 || rd_addr1 !== 4'd0 || led1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_fetch: busy=%b rd_addr=%0d led=%b, required 1 0 0000", busy1, rd_addr1, led1);
    end
    step();                                    // cycle 2: ON
    n_checks++;
    if (led1 !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_on: led=%b, required 0100", led1);
    end
    step();                                    // cycle 3: OFF
    n_checks++;
    if (led1 !== 4'b0000 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_off: led=%b done=%b, required 0000 0", led1, done1);
    end
    step();                                    // cycle 4: DONE
    n_checks++;
    if (done1 !== 1'b1 || led1 !== 4'b0000 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: done=%b led=%b busy=%b, required 1 0000 1", done1, led1, busy1);
    end
    step();                                    // cycle 5: IDLE
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || rd_addr1 !== 4'd0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b done=%b rd_addr=%0d, required 0 0 0", busy1, done1, rd_addr1);
    end
  endtask

  task automatic test_timing_scaled();
    logic [1:0] syms [0:2];
    logic [3:0] exp_led;
    int p, s, errs;
    syms[0] = 2'b01; syms[1] = 2'b11; syms[2] = 2'b00;
    mem2[0] = 2'b01; mem2[1] = 2'b11; mem2[2] = 2'b00;
    length2 = 4'd3;
    start2 = 1'b1;
    step(); start2 = 1'b0;
    errs = 0;
    // 7 cycles per symbol: FETCH, ON x4, OFF x2
    for (int c = 1; c <= 21; c++) begin
      p = (c - 1) % 7;
      s = (c - 1) / 7;
      exp_led = (p >= 1 && p <= 4) ? oh(syms[s]) : 4'b0000;
      n_checks++;
      if (led2 !== exp_led || rd_addr2 !== 4'(s) || done2 !== 1'b0) begin
        n_fail++;
        errs++;
        if (errs < 5)
          $display("FAIL scaled_cycle%0d: led=%b rd_addr=%0d done=%b, required %b %0d 0",
                   c, led2, rd_addr2, done2, exp_led, s);
      end
      step();
    end
    n_checks++;
    if (done2 !== 1'b1 || led2 !== 4'b0000) begin
      n_fail++;
      $display("FAIL scaled_done22: done=%b led=%b, required 1 0000", done2, led2);
    end
    step();
    n_checks++;
    if (busy2 !== 1'b0 || rd_addr2 !== 4'd0) begin
      n_fail++;
      $display("FAIL scaled_idle: busy=%b rd_addr=%0d, required 0 0", busy2, rd_addr2);
    end
  endtask

  task automatic test_length_bounds();
    int symbols, max_addr, done_cycle, bad;
    logic [3:0] prev_led;
    // length 0: immediate done, LEDs dark
    length1 = 4'd0;
    start1 = 1'b1;
    step(); start1 = 1'b0;
    n_checks++;
    if (done1 !== 1'b1 || led1 !== 4'b0000 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_done: done=%b led=%b busy=%b, required 1 0000 1", done1, led1, busy1);
    end
    step();
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || led1 !== 4'b0000) begin
      n_fail++;
      $display("FAIL len0_idle: done=%b busy=%b led=%b, required 0 0 0000", done1, busy1, led1);
    end
    // length 12 clamps to 10
    for (int i = 0; i < 16; i++) mem1[i] = 2'(i % 4);
    length1 = 4'd12;
    start1 = 1'b1;
    step(); start1 = 1'b0;
    length1 = 4'd2;                            // must be ignored once started
    symbols = 0; max_addr = 0; done_cycle = -1; bad = 0; prev_led = 4'b0000;
    for (int c = 1; c <= 60; c++) begin
      if (done1 === 1'b1) begin
        done_cycle = c;
        break;
      end
      if (led1 !== 4'b0000 && prev_led === 4'b0000) symbols++;
      if (led1 !== 4'b0000 && led1 !== oh(2'(rd_addr1 % 4))) bad++;
      if (int'(rd_addr1) > max_addr) max_addr = int'(rd_addr1);
      prev_led = led1;
      step();
    end
    n_checks++;
    if (done_cycle != 31) begin
      n_fail++;
      $display("FAIL len12_done_cycle: got %0d, required 31", done_cycle);
    end
    n_checks++;
    if (symbols != 10) begin
      n_fail++;
      $display("FAIL len12_symbols: got %0d, required 10", symbols);
    end
    n_checks++;
    if (max_addr != 9) begin
      n_fail++;
      $display("FAIL len12_max_addr: got %0d, required 9", max_addr);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL len12_led_values: %0d wrong cycles, required 0", bad);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mem1[0] = 2'b01; mem1[1] = 2'b10;
    length1 = 4'd2;
    start1 = 1'b1;
    step(); start1 = 1'b0;                     // cycle 1 FETCH
    step();                                    // cycle 2 ON
    start1 = 1'b1;                             // ignored while busy
    n_checks++;
    if (led1 !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_on0: led=%b, required 0010", led1);
    end
    step(); start1 = 1'b0;                     // cycle 3 OFF
    step();                                    // cycle 4 FETCH
    n_checks++;
    if (rd_addr1 !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_addr1: rd_addr=%0d, required 1", rd_addr1);
    end
    step();                                    // cycle 5 ON
    n_checks++;
    if (led1 !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_on1: led=%b, required 0100", led1);
    end
    step(); step();                            // cycle 7 DONE
    n_checks++;
    if (done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b, required 1", done1);
    end
    step();                                    // cycle 8 IDLE, no retrigger
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy1, done1);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    mem1[0] = 2'b11; length1 = 4'd3;
    start1 = 1'b1;
    step(); start1 = 1'b0;
    step();                                    // ON
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (led1 !== 4'b0000 || busy1 !== 1'b0 || rd_addr1 !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_blank: led=%b busy=%b rd_addr=%0d, required 0000 0 0", led1, busy1, rd_addr1);
    end
    saw_done = 1'b0;
    repeat (3) begin
      step();
      if (done1 !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      step();
      if (done1 !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: saw done=%b, required 0", saw_done);
    end
    length1 = 4'd1;
    start1 = 1'b1;
    step(); start1 = 1'b0;
    n_checks++;
    if (rd_addr1 !== 4'd0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: rd_addr=%0d busy=%b, required 0 1", rd_addr1, busy1);
    end
    step();
    n_checks++;
    if (led1 !== 4'b1000) begin
      n_fail++;
      $display("FAIL midreset_replay: led=%b, required 1000", led1);
    end
    repeat (3) step();
  endtask

`ifdef SEQ_PLAYER_HEX_EN
  task automatic test_hex();
    mem1[0] = 2'b00; mem1[1] = 2'b01; mem1[2] = 2'b10;
    length1 = 4'd3;
    n_checks++;
    if (hex1 !== 7'h7F) begin
      n_fail++;
      $display("FAIL hex_idle: hex=%b, required 1111111", hex1);
    end
    start1 = 1'b1;
    step(); start1 = 1'b0;                     // cycle 1
    step();                                    // cycle 2 ON sym0
    n_checks++;
    if (hex1 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL hex_digit0: hex=%b, required 1000000", hex1);
    end
    repeat (3) step();                         // cycle 5 ON sym1
    n_checks++;
    if (hex1 !== 7'b1111001) begin
      n_fail++;
      $display("FAIL hex_digit1: hex=%b, required 1111001", hex1);
    end
    repeat (3) step();                         // cycle 8 ON sym2
    n_checks++;
    if (hex1 !== 7'b0100100) begin
      n_fail++;
      $display("FAIL hex_digit2: hex=%b, required 0100100", hex1);
    end
    repeat (3) step();                         // cycle 11 IDLE
    n_checks++;
    if (hex1 !== 7'h7F) begin
      n_fail++;
      $display("FAIL hex_after_done: hex=%b, required 1111111", hex1);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; length1 = 4'd0; length2 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 2'b00;
      mem2[i] = 2'b00;
    end
    test_reset();
    test_single();
    test_timing_scaled();
    test_length_bounds();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_PLAYER_HEX_EN
    test_hex();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Downstream consumer of the random-sequence memory in the Simon Says game. Replays the first `length` stored 2-bit symbols on the LEDs during the FSM's blink phase.
- Each symbol is shown as a one-hot LED for a timed ON window, followed by a dark OFF gap. The decode matches the switch mapping (symbol v lights bit v).
- The top-level FSM pulses `start`, waits for `done`, then moves to acceptInput.

Parameters:
- TICKS_PER_UNIT, 25_000_000: CLOCK_50 cycles per timing unit (0.5 s). Set to 1 in simulation.
- ON_UNITS, 1: timing units each symbol is lit.
- OFF_UNITS, 1: timing units of dark gap after each symbol.
- DEPTH, 10: number of memory entries. Valid addresses are 0..DEPTH-1.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous active-low (driven from KEY[0]).
- start  in  1  one-cycle request to play; sampled only in IDLE.
- length  in  4  number of symbols to play, 0..15; values above DEPTH are clamped to DEPTH.
- rd_addr  out  4  memory read address; the memory returns data combinationally in the same cycle.
- rd_data  in  2  symbol at rd_addr.
- led_out  out  4  one-hot symbol display (LEDR[3:0]); 0 when dark.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback finishes.

Behaviour:
- Reset (async, immediate): state IDLE; idx, counter, symbol register = 0; led_out=0, busy=0, done=0, rd_addr=0. Reset mid-playback blanks the LEDs immediately and abandons the sequence. No done is issued.
- States: IDLE, FETCH, ON, OFF, DONE.
- IDLE:
  - start=1 and clamped length>=1: idx:=0, go to FETCH.
  - start=1 and length=0: go to DONE.
  - Otherwise remain in IDLE.
  - The clamped length is latched on the start cycle; later changes to `length` are ignored.
- FETCH (1 cycle): rd_addr=idx, symbol:=rd_data. Load counter with ON_UNITS*TICKS_PER_UNIT-1, go to ON.
- ON:
  - led_out = 1<<symbol (00→0001, 01→0010, 10→0100, 11→1000).
  - Counter decrements each cycle; at 0, load OFF_UNITS*TICKS_PER_UNIT-1 and go to OFF.
  - ON therefore lasts exactly ON_UNITS*TICKS_PER_UNIT cycles.
- OFF:
  - led_out=0 for exactly OFF_UNITS*TICKS_PER_UNIT cycles.
  - At counter 0: if idx==len-1 go to DONE, else idx:=idx+1 and go to FETCH.
- DONE (1 cycle): done=1, led_out=0; go to IDLE.
- Timing: cycles per symbol = 1 + (ON_UNITS+OFF_UNITS)*TICKS_PER_UNIT. Total playback = len × that, plus 1 DONE cycle.
- rd_addr holds idx in every state and never exceeds DEPTH-1. It is 0 in IDLE.
- start asserted while busy is ignored. There is no queuing.
- Counter width: $clog2(max(ON_UNITS,OFF_UNITS)*TICKS_PER_UNIT) bits, minimum 1. Products are computed as 32-bit constants.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro SEQ_PLAYER_HEX_EN.
- Defined: extra output hex_out[6:0] (active-low 7-segment, feeds HEX0).
  - Shows the digit idx (0–9) during FETCH, ON and OFF.
  - Shows blank 7'h7F in IDLE, DONE and reset.
  - Registered, so it updates one cycle after idx changes.
- Undefined: no hex_out port and no segment logic; all other behaviour is identical.

Decomposition:
- Shared package simon_pkg holds:
  - symbol_t (logic [1:0]);
  - SEQ_DEPTH=10;
  - the player state enum player_state_t (IDLE, FETCH, ON, OFF, DONE);
  - function seg7_digit (4-bit → 7-bit active-low), also used by the top-level HEX0 driver.
- Sub-module: instantiate the existing decoder_2_4 for the symbol→led_out one-hot decode.
- All counters and the FSM stay inside sequence_player.

Test Plan (TICKS_PER_UNIT=1, ON_UNITS=1, OFF_UNITS=1 unless stated):
1. Reset: hold rst_n=0 with start=1 → led_out=0, busy=0, done=0, rd_addr=0. Deassert rst_n and keep start=0 → stays IDLE.
2. mem[0]=2'b10, length=1, start at cycle 0 → cycle 1 FETCH with rd_addr=0; cycle 2 led_out=4'b0100; cycle 3 led_out=0; cycle 4 done=1; cycle 5 busy=0.
3. TICKS_PER_UNIT=2, ON_UNITS=2, mem={01,11,00}, length=3:
   - led 0010 for 4 cycles, dark 2; led 1000 for 4, dark 2; led 0001 for 4, dark 2;
   - done at cycle 22 after start; rd_addr steps 0,1,2.
4. length=0 → done=1 the cycle after start, led_out never nonzero. length=12 with mem[i]=i%4 → exactly 10 symbols played, rd_addr max 9.
5. Extra start pulse during ON is ignored (sequence and done timing unchanged). rst_n=0 mid-ON → led_out=0 immediately, no done. After release, a new start replays from idx 0.
6. With SEQ_PLAYER_HEX_EN defined, length=3 → hex_out=7'h7F in IDLE; 7'b1000000 ("0"), then 7'b1111001 ("1"), then 7'b0100100 ("2") during the successive symbols; 7'h7F after done.
